psi_stream: RTL and testbench

PSI_STREAM -- requirements
Module: psi_stream

---
 rtl/psi_stream.sv | 181 ++++++++++++++++++
 tb/tb_psi_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/psi_stream.sv
// psi_stream: streaming private-set-intersection accumulator.
// Collects N party bit-vectors over a valid/ready stream, then presents
// the per-element result o and its popcount card over a valid/ready output.
// Optional macro PSI_THRESHOLD_EN: an element is in the result when at least
// T parties hold it, instead of requiring all N parties to hold it.
module psi_stream #(
    parameter int W = 10,
    parameter int N = 4,
    parameter int T = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               o,
    output logic [$clog2(W+1)-1:0]     card,
    output logic [$clog2(N+1)-1:0]     party_cnt
);

    localparam int CW = $clog2(N + 1);
    localparam int KW = $clog2(W + 1);

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_DONE  = 1'b1;

    localparam logic [CW-1:0] N_C   = CW'(N);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // Parameter sanity: reject illegal party count or threshold at elaboration.
    if (N < 2 || N > 64) begin : g_bad_n
        $error("psi_stream: N out of range");
    end
    if (T < 1 || T > N) begin : g_bad_t
        $error("psi_stream: T out of range");
    end

    function automatic logic [KW-1:0] popcount(input logic [W-1:0] v);
        logic [KW-1:0] c;
        c = {KW{1'b0}};
        for (int i = 0; i < W; i++) begin
            c = c + KW'(v[i]);
        end
        return c;
    endfunction

    logic            state_q, state_d;
    logic [CW-1:0]   party_cnt_q, party_cnt_d;
    logic [W-1:0]    o_q, o_d;
    logic [KW-1:0]   card_q, card_d;
    logic [W-1:0]    result_s;     // result if the current transfer is the last one
    logic            acc_clear_s;  // reinitialise the accumulator this cycle
    logic            acc_upd_s;    // fold in_data into the accumulator this cycle

    // Round control: transfers, entry to DONE, result handshake and abort.
    always_comb begin
        state_d     = state_q;
        party_cnt_d = party_cnt_q;
        o_d         = o_q;
        card_d      = card_q;
        acc_clear_s = 1'b0;
        acc_upd_s   = 1'b0;
        if (clr) begin
            state_d     = ST_ACCUM;
            party_cnt_d = {CW{1'b0}};
            o_d         = {W{1'b0}};
            card_d      = {KW{1'b0}};
            acc_clear_s = 1'b1;
        end else if (state_q == ST_DONE) begin
            if (out_ready) begin
                state_d     = ST_ACCUM;
                party_cnt_d = {CW{1'b0}};
                o_d         = {W{1'b0}};
                card_d      = {KW{1'b0}};
                acc_clear_s = 1'b1;
            end else begin
                state_d = ST_DONE;
            end
        end else if (in_valid) begin
            party_cnt_d = party_cnt_q + ONE_C;
            acc_upd_s   = 1'b1;
            if (party_cnt_q == (N_C - ONE_C)) begin
                state_d = ST_DONE;
                o_d     = result_s;
                card_d  = popcount(result_s);
            end else begin
                state_d = ST_ACCUM;
            end
        end else begin
            state_d = ST_ACCUM;
        end
    end

    // Round control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            party_cnt_q <= {CW{1'b0}};
            o_q         <= {W{1'b0}};
            card_q      <= {KW{1'b0}};
        end else begin
            state_q     <= state_d;
            party_cnt_q <= party_cnt_d;
            o_q         <= o_d;
            card_q      <= card_d;
        end
    end

`ifdef PSI_THRESHOLD_EN
    localparam logic [CW-1:0] T_C = CW'(T);

    logic [CW-1:0] ctr_q   [W];
    logic [CW-1:0] ctr_d   [W];
    logic [CW-1:0] ctr_nxt_s [W];

    // Per-element saturating vote counters and the threshold decision.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            if (in_data[i] && (ctr_q[i] != N_C)) begin
                ctr_nxt_s[i] = ctr_q[i] + ONE_C;
            end else begin
                ctr_nxt_s[i] = ctr_q[i];
            end
            result_s[i] = (ctr_nxt_s[i] >= T_C);
            if (acc_clear_s) begin
                ctr_d[i] = {CW{1'b0}};
            end else if (acc_upd_s) begin
                ctr_d[i] = ctr_nxt_s[i];
            end else begin
                ctr_d[i] = ctr_q[i];
            end
        end
    end

    // Vote counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                ctr_q[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end
`else
    logic [W-1:0] acc_q, acc_d;

    // Intersection accumulator: running AND of all accepted vectors.
    always_comb begin
        result_s = acc_q & in_data;
        if (acc_clear_s) begin
            acc_d = {W{1'b1}};
        end else if (acc_upd_s) begin
            acc_d = result_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Intersection accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {W{1'b1}};
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign o         = o_q;
    assign card      = card_q;
    assign party_cnt = party_cnt_q;

endmodule

// File: tb/tb_psi_stream.sv
// Self-checking bench for psi_stream (W=8, N=4, T=3).
module tb_psi_stream;

    localparam int W = 8;
    localparam int N = 4;
    localparam int T = 3;

`ifdef PSI_THRESHOLD_EN
    localparam logic [7:0] E030_O = 8'hB4;
    localparam logic [3:0] E030_C = 4'd4;
    localparam logic [7:0] E032_O = 8'h0F;
    localparam logic [3:0] E032_C = 4'd4;
`else
    localparam logic [7:0] E030_O = 8'h30;
    localparam logic [3:0] E030_C = 4'd2;
    localparam logic [7:0] E032_O = 8'h01;
    localparam logic [3:0] E032_C = 4'd1;
`endif
    // 0x07,0x03,0x05,0x01: element 0 held by 4 parties, elements 1 and 2 by 2.
    // Below the threshold of 3 as well as below N, so both builds give 0x01.
    localparam logic [7:0] E034_O = 8'h01;
    localparam logic [3:0] E034_C = 4'd1;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] o;
    logic [3:0] card;
    logic [2:0] party_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    bit         m_done;
    logic [7:0] m_q[$];
    logic [7:0] m_o;
    int         m_card;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       r;
        logic       ov;
        logic [7:0] eo;
        logic [3:0] ec;
        logic [2:0] pc;
    } vec_t;

    vec_t tbl[18];

    psi_stream #(.W(W), .N(N), .T(T)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .card(card), .party_cnt(party_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_done = 1'b0;
        m_q.delete();
        m_o    = 8'h00;
        m_card = 0;
    endtask

    // Result from the whole set of accepted vectors, element by element.
    task automatic model_result();
        logic [7:0] r;
        int k;
        r = 8'h00;
        m_card = 0;
        for (int b = 0; b < 8; b++) begin
            k = 0;
            foreach (m_q[j]) k += int'(m_q[j][b]);
`ifdef PSI_THRESHOLD_EN
            r[b] = (k >= T);
`else
            r[b] = (k == N);
`endif
            if (r[b]) m_card++;
        end
        m_o = r;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c, input logic r);
        if (c) begin
            model_reset();
        end else if (m_done) begin
            if (r) model_reset();
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == N) begin
                model_result();
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".in_ready"},  int'(in_ready),  int'(!m_done));
        check({tag, ".out_valid"}, int'(out_valid), int'(m_done));
        check({tag, ".o"},         int'(o),         int'(m_o));
        check({tag, ".card"},      int'(card),      m_card);
        check({tag, ".party_cnt"}, int'(party_cnt), m_done ? N : m_q.size());
    endtask

    // One clock cycle: drive inputs, predict, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic r, input string tag);
        in_valid  = v;
        in_data   = d;
        clr       = c;
        out_ready = r;
        model_step(v, d, c, r);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        #10;
        rst = 1'b0;

        // Back-to-back round, stalled result, handshake, clr on 3rd transfer.
        tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd1};
        tbl[1]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd2};
        tbl[2]  = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd3};
        tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, E030_O, E030_C, 3'd4};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, E030_O, E030_C, 3'd4};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00,  4'd0,   3'd0};
        tbl[10] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd1};
        tbl[11] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h00,  4'd0,   3'd2};
        tbl[12] = '{1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00,  4'd0,   3'd0};
        tbl[13] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd1};
        tbl[14] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd2};
        tbl[15] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00,  4'd0,   3'd3};
        tbl[16] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, E032_O, E032_C, 3'd4};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00,  4'd0,   3'd0};

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.ov", i), int'(out_valid), int'(tbl[i].ov));
            check($sformatf("tbl%0d.ir", i), int'(in_ready),  int'(!tbl[i].ov));
            check($sformatf("tbl%0d.o", i),  int'(o),         int'(tbl[i].eo));
            check($sformatf("tbl%0d.card", i), int'(card),    int'(tbl[i].ec));
            check($sformatf("tbl%0d.pc", i), int'(party_cnt), int'(tbl[i].pc));
        end

        // Asynchronous reset in the middle of a cycle after two transfers.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, "rst_a");
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, "rst_b");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        check("async_rst.pc_now", int'(party_cnt), 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0, "after_rst");
        check("after_rst.o", int'(o), 8'hAA);
        check("after_rst.card", int'(card), 4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "after_rst_hs");

        // Threshold comparison vector, gap-free.
        cyc(1'b1, 8'h07, 1'b0, 1'b0, "thr");
        cyc(1'b1, 8'h03, 1'b0, 1'b0, "thr");
        cyc(1'b1, 8'h05, 1'b0, 1'b0, "thr");
        cyc(1'b1, 8'h01, 1'b0, 1'b0, "thr");
        check("thr.o", int'(o), int'(E034_O));
        check("thr.card", int'(card), int'(E034_C));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "thr_hs");

        // Same vectors with idle gaps: data on idle cycles must be ignored.
        cyc(1'b1, 8'h07, 1'b0, 1'b0, "gap");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "gap");
        check("gap.pc1", int'(party_cnt), 1);
        cyc(1'b1, 8'h03, 1'b0, 1'b0, "gap");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "gap");
        cyc(1'b0, 8'hFF, 1'b0, 1'b0, "gap");
        check("gap.pc2", int'(party_cnt), 2);
        cyc(1'b1, 8'h05, 1'b0, 1'b0, "gap");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "gap");
        cyc(1'b1, 8'h01, 1'b0, 1'b0, "gap");
        check("gap.o", int'(o), int'(E034_O));
        check("gap.card", int'(card), int'(E034_C));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "gap_hs");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 40) == 0),
                1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
